// File: rtl/seq_sched_pkg.sv
// Shared types and constants for the shared serial-detector scheduler.
// Holds the FSM state enum, default detector pattern and width helper.
package seq_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    REPORT = 2'd2
  } state_t;

  localparam int                   DEF_PAT_W   = 4;
  localparam logic [DEF_PAT_W-1:0] DEF_PATTERN = 4'b1101;

  // Bits needed to index n items, never less than one.
  function automatic int width_of(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/seq_det_core.sv
// Generic overlapping Mealy pattern detector, first-received bit is PATTERN[PAT_W-1].
// A fill mask blocks matches until PAT_W-1 real bits have arrived since the last clear.
module seq_det_core
  import seq_sched_pkg::*;
#(
  parameter int               PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEF_PATTERN)
) (
  input  logic clk,
  input  logic n_reset,
  input  logic clr,
  input  logic en,
  input  logic d_in,
  output logic d_out
);

  localparam int HW = PAT_W - 1;

  logic [HW-1:0]    hist_p0;
  logic [HW-1:0]    vld_p0;
  logic [PAT_W-1:0] win;

  assign win   = {hist_p0, d_in};
  assign d_out = en && (&vld_p0) && (win == PATTERN);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      hist_p0 <= '0;
      vld_p0  <= '0;
    end else if (clr) begin
      hist_p0 <= '0;
      vld_p0  <= '0;
    end else if (en) begin
      hist_p0 <= win[HW-1:0];
      vld_p0  <= (vld_p0 << 1) | HW'(1);
    end
  end

endmodule

// File: rtl/seq_det_scheduler.sv
// Arbitrates NUM_REQ requesters onto one serial detector and reports match counts.
// Build option SEQ_SCHED_FIXED_PRIO_EN: fixed priority (lowest index) instead of round-robin.
module seq_det_scheduler
  import seq_sched_pkg::*;
#(
  parameter int               NUM_REQ = 4,
  parameter int               WORD_W  = 8,
  parameter int               PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEF_PATTERN),
  parameter int               ID_W    = width_of(NUM_REQ),
  parameter int               CNT_W   = width_of(WORD_W + 1)
) (
  input  logic                      clk,
  input  logic                      n_reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*WORD_W-1:0] req_word,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      busy,
  output logic                      ser_bit,
  output logic                      done,
  output logic [ID_W-1:0]           done_id,
  output logic [CNT_W-1:0]          match_cnt
);

  localparam int IDX_W = width_of(WORD_W);

  state_t            state_p0, state_nx;
  logic [WORD_W-1:0] word_p0;
  logic [WORD_W-1:0] win_word;
  logic [IDX_W-1:0]  idx_p0;
  logic [CNT_W-1:0]  cnt_p0, cnt_nx;
  logic [ID_W-1:0]   id_p0, win_id, pos;
  logic              any_req, accept, last_bit;
  logic              det_en, det_clr, det_hit;

  assign any_req  = |req;
  assign accept   = (state_p0 == IDLE) && any_req;
  assign last_bit = (state_p0 == SHIFT) && (idx_p0 == '0);
  assign cnt_nx   = cnt_p0 + CNT_W'(det_hit);

`ifdef SEQ_SCHED_FIXED_PRIO_EN
  always_comb begin
    win_id = '0;
    pos    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) win_id = ID_W'(i);
    end
  end
`else
  logic [ID_W-1:0] last_p0;

  // Scan from furthest to nearest after the last winner so the nearest hit lands last.
  always_comb begin
    win_id = '0;
    pos    = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      pos = ID_W'((int'(last_p0) + k) % NUM_REQ);
      if (req[pos]) win_id = pos;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset)    last_p0 <= ID_W'(NUM_REQ - 1);
    else if (accept) last_p0 <= win_id;
  end
`endif

  always_comb begin
    win_word = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == win_id) win_word = req_word[i*WORD_W +: WORD_W];
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) state_p0 <= IDLE;
    else          state_p0 <= state_nx;
  end

  // FSM: next state
  always_comb begin
    state_nx = state_p0;
    case (state_p0)
      IDLE:    if (any_req) state_nx = SHIFT;
      SHIFT:   if (last_bit) state_nx = REPORT;
      REPORT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy    = (state_p0 != IDLE);
    det_en  = (state_p0 == SHIFT);
    det_clr = (state_p0 == IDLE);
    ser_bit = (state_p0 == SHIFT) ? word_p0[idx_p0] : 1'b0;
  end

  // Stage p0: job word capture (datapath, not reset; ser_bit is gated outside SHIFT)
  always_ff @(posedge clk) begin
    if (accept) word_p0 <= win_word;
  end

  // Stage p0: control, counters and result registers
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      grant     <= '0;
      done      <= 1'b0;
      done_id   <= '0;
      match_cnt <= '0;
      idx_p0    <= '0;
      cnt_p0    <= '0;
      id_p0     <= '0;
    end else begin
      grant <= accept ? (NUM_REQ'(1) << win_id) : '0;
      done  <= last_bit;
      if (accept) begin
        idx_p0 <= IDX_W'(WORD_W - 1);
        cnt_p0 <= '0;
        id_p0  <= win_id;
      end else if (state_p0 == SHIFT) begin
        idx_p0 <= idx_p0 - 1'b1;
        cnt_p0 <= cnt_nx;
      end
      if (last_bit) begin
        done_id   <= id_p0;
        match_cnt <= cnt_nx;
      end
    end
  end

  seq_det_core #(
    .PAT_W  (PAT_W),
    .PATTERN(PATTERN)
  ) u_det (
    .clk    (clk),
    .n_reset(n_reset),
    .clr    (det_clr),
    .en     (det_en),
    .d_in   (ser_bit),
    .d_out  (det_hit)
  );

endmodule

// File: tb/tb_seq_det_scheduler.sv
// Scoreboard bench for seq_det_scheduler: randomized and directed job batches
// against a reference arbitration/match-count model; honours SEQ_SCHED_FIXED_PRIO_EN.
module tb_seq_det_scheduler;

  localparam int           NR  = 4;
  localparam int           WW  = 8;
  localparam int           PW  = 4;
  localparam logic [PW-1:0] PAT = 4'b1101;
  localparam int           IW  = 2;
  localparam int           CW  = 4;

  logic                clk = 1'b0;
  logic                n_reset = 1'b0;
  logic [NR-1:0]       req = '0;
  logic [NR*WW-1:0]    req_word = '0;
  logic [NR-1:0]       grant;
  logic                busy, ser_bit, done;
  logic [IW-1:0]       done_id;
  logic [CW-1:0]       match_cnt;

  typedef struct {int id; int cnt;} res_t;
  res_t exp_q[$];
  int   gexp_q[$];
  int   gtime_q[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_grant_cyc = 0;
  int m_last = NR - 1;

  seq_det_scheduler #(.NUM_REQ(NR), .WORD_W(WW)) dut (
    .clk      (clk),
    .n_reset  (n_reset),
    .req      (req),
    .req_word (req_word),
    .grant    (grant),
    .busy     (busy),
    .ser_bit  (ser_bit),
    .done     (done),
    .done_id  (done_id),
    .match_cnt(match_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Count overlapping occurrences of PAT reading the word MSB first.
  function automatic int ref_count(input logic [WW-1:0] w);
    int c = 0;
    for (int s = 0; s <= WW - PW; s++)
      if (w[WW-1-s -: PW] == PAT) c++;
    return c;
  endfunction

  function automatic int pick(input logic [NR-1:0] pend);
`ifdef SEQ_SCHED_FIXED_PRIO_EN
    for (int i = 0; i < NR; i++) if (pend[i]) return i;
`else
    for (int k = 1; k <= NR; k++) if (pend[(m_last + k) % NR]) return (m_last + k) % NR;
`endif
    return -1;
  endfunction

  // Monitor: compares every grant and result against the scoreboard queues.
  always @(negedge clk) begin
    if (n_reset) begin
      if (grant != '0) begin
        if (gexp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_grant: got %0d expected none", int'(grant));
        end else begin
          int g;
          g = gexp_q.pop_front();
          chk("grant", int'(grant), 1 << g);
          chk("busy_at_grant", int'(busy), 1);
        end
        last_grant_cyc = cyc;
        gtime_q.push_back(cyc);
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_done: got id %0d cnt %0d expected none", int'(done_id), int'(match_cnt));
        end else begin
          res_t e;
          e = exp_q.pop_front();
          chk("done_id", int'(done_id), e.id);
          chk("match_cnt", int'(match_cnt), e.cnt);
          chk("latency", cyc - last_grant_cyc, WW);
        end
      end
    end
  end

  task automatic run_batch(input logic [NR-1:0] mask, input logic [NR*WW-1:0] words, input bit chk_ser);
    logic [NR-1:0] pend;
    int n, served, budget, w;
    pend = mask;
    n = 0;
    while (pend != '0) begin
      w = pick(pend);
      gexp_q.push_back(w);
      exp_q.push_back('{id: w, cnt: ref_count(words[w*WW +: WW])});
`ifndef SEQ_SCHED_FIXED_PRIO_EN
      m_last = w;
`endif
      pend[w] = 1'b0;
      n++;
    end
    gtime_q.delete();
    @(negedge clk);
    req_word = words;
    req = mask;
    served = 0;
    budget = 0;
    while (served < n && budget < n * (WW + 2) + 20) begin
      @(negedge clk);
      budget++;
      for (int i = 0; i < NR; i++) begin
        if (req[i] && grant[i]) begin
          req[i] = 1'b0;
          served++;
          if (chk_ser) begin
            for (int j = 0; j < WW; j++) begin
              chk("ser_bit", int'(ser_bit), int'(words[i*WW + WW - 1 - j]));
              if (j < WW - 1) @(negedge clk);
            end
          end
        end
      end
    end
    if (served < n) chk("grant_timeout", served, n);
    req = '0;
    budget = 0;
    while (exp_q.size() != 0 && budget < 3 * WW) begin
      @(negedge clk);
      budget++;
    end
    if (exp_q.size() != 0) begin
      chk("done_timeout", exp_q.size(), 0);
      exp_q.delete();
      gexp_q.delete();
    end
    for (int k = 1; k < gtime_q.size(); k++)
      chk("grant_spacing", gtime_q[k] - gtime_q[k-1], WW + 2);
    @(negedge clk);
    @(negedge clk);
    chk("busy_idle", int'(busy), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NR*WW-1:0] wv;
    int budget;

    repeat (3) @(negedge clk);
    chk("rst_grant", int'(grant), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ser_bit", int'(ser_bit), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_done_id", int'(done_id), 0);
    chk("rst_match_cnt", int'(match_cnt), 0);
    n_reset = 1'b1;
    @(negedge clk);

    run_batch(4'b0001, {24'h0, 8'b11011011}, 1'b1);
    run_batch(4'b0100, {8'h00, 8'hFF, 16'h0}, 1'b0);
    run_batch(4'b0100, {8'h00, 8'h00, 16'h0}, 1'b0);
    run_batch(4'b0100, {8'h00, 8'b01101101, 16'h0}, 1'b0);
    run_batch(4'b1111, {4{8'b11010000}}, 1'b0);
    run_batch(4'b1111, {4{8'b11010000}}, 1'b0);
    run_batch(4'b1110, {4{8'b11011101}}, 1'b0);
    run_batch(4'b0010, {16'h0, 8'b00000110, 8'h0}, 1'b0);
    run_batch(4'b0010, {16'h0, 8'b10000000, 8'h0}, 1'b0);

    for (int b = 0; b < 25; b++) begin
      for (int i = 0; i < NR; i++) wv[i*WW +: WW] = WW'($urandom);
      run_batch(NR'($urandom_range(1, (1 << NR) - 1)), wv, 1'b0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Reset in the middle of a job: outputs clear at once and no result appears.
    gtime_q.delete();
    gexp_q.push_back(pick(4'b0001));
    @(negedge clk);
    req_word = {24'h0, 8'b11011011};
    req = 4'b0001;
    budget = 0;
    while (grant == '0 && budget < 10) begin
      @(negedge clk);
      budget++;
    end
    chk("mid_grant_seen", int'(grant), 1);
    req = '0;
    repeat (3) @(negedge clk);
    #2 n_reset = 1'b0;
    #1;
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_ser_bit", int'(ser_bit), 0);
    chk("async_rst_done_id", int'(done_id), 0);
    chk("async_rst_match_cnt", int'(match_cnt), 0);
    chk("async_rst_grant", int'(grant), 0);
    gexp_q.delete();
    exp_q.delete();
    m_last = NR - 1;
    repeat (3) @(negedge clk);
    n_reset = 1'b1;
    repeat (WW + 4) @(negedge clk);
    run_batch(4'b1001, {8'b11010000, 16'h0, 8'b01101101}, 1'b0);

    chk("queues_empty", exp_q.size() + gexp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
